// File: rtl/dkong_dl_ctrl.sv
// Download sequencer for the Donkey Kong core: routes HPS ROM bytes to the
// per-region write ports, validates the image and owns the core reset.
module dkong_dl_ctrl #(
  parameter int CPU_SIZE   = 16384,
  parameter int SND_SIZE   = 4096,
  parameter int TILE_SIZE  = 4096,
  parameter int OBJ_SIZE   = 8192,
  parameter int PROM_SIZE  = 768,
  parameter int SETTLE_CYC = 1024
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic        I_DL_ACTIVE,
  input  logic        I_DL_WR,
  input  logic [18:0] I_DL_ADDR,
  input  logic [7:0]  I_DL_DATA,
  input  logic        I_RST_REQ,
  output logic [15:0] O_WR_ADDR,
  output logic [7:0]  O_WR_DATA,
  output logic        O_WR_CPU,
  output logic        O_WR_SND,
  output logic        O_WR_TILE,
  output logic        O_WR_OBJ,
  output logic        O_WR_PROM,
  output logic        O_CORE_RESETn,
  output logic        O_DL_OK,
  output logic        O_DL_ERR,
  output logic [18:0] O_BYTE_CNT
);

  localparam logic [18:0] SND_BASE  = 19'(CPU_SIZE);
  localparam logic [18:0] TILE_BASE = 19'(CPU_SIZE + SND_SIZE);
  localparam logic [18:0] OBJ_BASE  = 19'(CPU_SIZE + SND_SIZE + TILE_SIZE);
  localparam logic [18:0] PROM_BASE = 19'(CPU_SIZE + SND_SIZE + TILE_SIZE + OBJ_SIZE);
  localparam logic [18:0] TOTAL     = 19'(CPU_SIZE + SND_SIZE + TILE_SIZE + OBJ_SIZE + PROM_SIZE);
  localparam int          SW        = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [18:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          rstn_q, rstn_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [4:0]    strb_q, strb_d;
  logic [4:0]    region;
  logic [18:0]   base;
  logic          accept;

  // Strobe bit order: CPU, SND, TILE, OBJ, PROM; out-of-range leaves region empty.
  always_comb begin
    region = 5'b00000;
    base   = '0;
    if (I_DL_ADDR < SND_BASE) begin
      region = 5'b00001;
    end else if (I_DL_ADDR < TILE_BASE) begin
      region = 5'b00010;
      base   = SND_BASE;
    end else if (I_DL_ADDR < OBJ_BASE) begin
      region = 5'b00100;
      base   = TILE_BASE;
    end else if (I_DL_ADDR < PROM_BASE) begin
      region = 5'b01000;
      base   = OBJ_BASE;
    end else if (I_DL_ADDR < TOTAL) begin
      region = 5'b10000;
      base   = PROM_BASE;
    end
  end

  assign accept = (state_q == ST_LOAD) && I_DL_ACTIVE && I_DL_WR;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ok_d     = ok_q;
    err_d    = err_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = 5'b00000;

    if (accept) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 19'd1;
      if (region != 5'b00000) begin
        strb_d = region;
        addr_d = 16'(I_DL_ADDR - base);
        data_d = I_DL_DATA;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_HOLD, ST_ERR, ST_RUN: begin
        if (I_DL_ACTIVE) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == ST_RUN && I_RST_REQ) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_LOAD: begin
        if (!I_DL_ACTIVE) begin
          if (cnt_q == TOTAL && !ovf_q) begin
            state_d = ST_SETTLE;
            ok_d    = 1'b1;
            // The cycle that observed the end of the download counts as the first settle cycle.
            settle_d = SW'(1);
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (I_RST_REQ) begin
          settle_d = '0;
        end else if (settle_q >= SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  assign rstn_d = (state_d == ST_RUN);

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q  <= ST_HOLD;
      settle_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      rstn_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      rstn_q   <= rstn_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
    end
  end

  assign {O_WR_PROM, O_WR_OBJ, O_WR_TILE, O_WR_SND, O_WR_CPU} = strb_q;
  assign O_WR_ADDR     = addr_q;
  assign O_WR_DATA     = data_q;
  assign O_CORE_RESETn = rstn_q;
  assign O_DL_OK       = ok_q;
  assign O_DL_ERR      = err_q;
  assign O_BYTE_CNT    = cnt_q;

endmodule

// File: tb/tb_dkong_dl_ctrl.sv
// Randomized bench for dkong_dl_ctrl: a download-level reference model runs
// alongside the DUT and every cycle is compared through checkOutput.
module tb_dkong_dl_ctrl;

  localparam int CPU_SIZE   = 16384;
  localparam int SND_SIZE   = 4096;
  localparam int TILE_SIZE  = 4096;
  localparam int OBJ_SIZE   = 8192;
  localparam int PROM_SIZE  = 768;
  localparam int TOTAL      = 33536;
  localparam int SETTLE_CYC = 1024;
  localparam int CNT_MAX    = 524287;

  logic        clock = 1'b0;
  logic        rstn, act, wr, req;
  logic [18:0] addr;
  logic [7:0]  data;
  logic [15:0] wrAddr;
  logic [7:0]  wrData;
  logic        wCpu, wSnd, wTile, wObj, wProm;
  logic        coreRstn, dlOk, dlErr;
  logic [18:0] byteCnt;

  dkong_dl_ctrl dut (
    .I_CLK_24576M (clock),
    .I_RESETn     (rstn),
    .I_DL_ACTIVE  (act),
    .I_DL_WR      (wr),
    .I_DL_ADDR    (addr),
    .I_DL_DATA    (data),
    .I_RST_REQ    (req),
    .O_WR_ADDR    (wrAddr),
    .O_WR_DATA    (wrData),
    .O_WR_CPU     (wCpu),
    .O_WR_SND     (wSnd),
    .O_WR_TILE    (wTile),
    .O_WR_OBJ     (wObj),
    .O_WR_PROM    (wProm),
    .O_CORE_RESETn(coreRstn),
    .O_DL_OK      (dlOk),
    .O_DL_ERR     (dlErr),
    .O_BYTE_CNT   (byteCnt)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sizeOf(input int r);
    case (r)
      0: return CPU_SIZE;
      1: return SND_SIZE;
      2: return TILE_SIZE;
      3: return OBJ_SIZE;
      default: return PROM_SIZE;
    endcase
  endfunction

  function automatic int baseOf(input int r);
    int b = 0;
    for (int k = 0; k < r; k++) b += sizeOf(k);
    return b;
  endfunction

  function automatic int regionOf(input int a);
    for (int r = 0; r < 5; r++)
      if (a >= baseOf(r) && a < baseOf(r) + sizeOf(r)) return r;
    return -1;
  endfunction

  // Reference model: tracks the download session, the settle countdown and
  // whether the core is released, then compares all outputs each cycle.
  bit          monEn = 0;
  bit          mLoading, mSettling, mRunning, mOk, mErr, mOvf;
  int          mCount, mSettleLeft;
  logic [4:0]  expStrb;
  logic [15:0] expAddr;
  logic [7:0]  expData;
  int          strbCnt [5];
  logic        sRst, sA, sW, sReq;
  logic [18:0] sAddr;
  logic [7:0]  sData;

  always @(posedge clock) begin
    sRst = rstn; sA = act; sW = wr; sReq = req; sAddr = addr; sData = data;
    expStrb = 5'b0;
    if (!sRst) begin
      mLoading = 0; mSettling = 0; mRunning = 0;
      mOk = 0; mErr = 0; mOvf = 0; mCount = 0; mSettleLeft = 0;
    end else if (mLoading) begin
      if (!sA) begin
        mLoading = 0;
        if (mCount == TOTAL && !mOvf) begin
          mOk = 1; mSettling = 1; mSettleLeft = SETTLE_CYC - 1;
        end else begin
          mErr = 1;
        end
      end else if (sW) begin
        int r;
        if (mCount < CNT_MAX) mCount++;
        r = regionOf(int'(sAddr));
        if (r >= 0) begin
          expStrb = 5'(1 << r);
          expAddr = 16'(int'(sAddr) - baseOf(r));
          expData = sData;
        end else begin
          mOvf = 1;
        end
      end
    end else if (mSettling) begin
      if (sReq) mSettleLeft = SETTLE_CYC;
      else mSettleLeft--;
      if (mSettleLeft == 0) begin
        mSettling = 0; mRunning = 1;
      end
    end else if (sA) begin
      mLoading = 1; mRunning = 0; mCount = 0; mOk = 0; mErr = 0; mOvf = 0;
    end else if (mRunning && sReq) begin
      mRunning = 0; mSettling = 1; mSettleLeft = SETTLE_CYC;
    end
    #3;
    if (monEn) begin
      checkOutput("strobes", {wProm, wObj, wTile, wSnd, wCpu}, expStrb);
      if (expStrb != 5'b0) begin
        checkOutput("wrAddr", wrAddr, expAddr);
        checkOutput("wrData", wrData, expData);
      end
      checkOutput("coreRstn", coreRstn, mRunning);
      checkOutput("dlOk", dlOk, mOk);
      checkOutput("dlErr", dlErr, mErr);
      checkOutput("byteCnt", byteCnt, mCount);
    end
    if (wCpu)  strbCnt[0]++;
    if (wSnd)  strbCnt[1]++;
    if (wTile) strbCnt[2]++;
    if (wObj)  strbCnt[3]++;
    if (wProm) strbCnt[4]++;
  end

  task automatic applyStimulus(input logic a, input logic w, input logic [18:0] ad,
                               input logic [7:0] d, input logic rq);
    act = a; wr = w; addr = ad; data = d; req = rq;
    @(posedge clock);
    #1;
  endtask

  // One download session; extraAt inserts an out-of-range write before that index.
  task automatic download(input int nBytes, input int extraAt, input int gapPct,
                          input bit randAddr, input bit directed);
    logic [18:0] a;
    logic [7:0]  d;
    applyStimulus(1, 0, '0, '0, 0);
    for (int i = 0; i < nBytes; i++) begin
      if (i == extraAt) applyStimulus(1, 1, 19'h09000, 8'($urandom), 0);
      while (gapPct > 0 && $urandom_range(99) < gapPct)
        applyStimulus(1, 0, 19'($urandom_range(TOTAL)), 8'($urandom), 0);
      a = randAddr ? 19'($urandom_range(TOTAL + 4095)) : 19'(i);
      d = (directed && i == 'h4000) ? 8'hA5 : 8'($urandom);
      applyStimulus(1, 1, a, d, 0);
      if (directed && i == 'h4000) begin
        checkOutput("snd0Strobe", wSnd, 1'b1);
        checkOutput("snd0Cpu", wCpu, 1'b0);
        checkOutput("snd0Addr", wrAddr, 16'h0000);
        checkOutput("snd0Data", wrData, 8'hA5);
      end
      if (directed && i == 'h8000) begin
        checkOutput("prom0Strobe", wProm, 1'b1);
        checkOutput("prom0Addr", wrAddr, 16'h0000);
      end
    end
    applyStimulus(0, 1'($urandom_range(1)), 19'($urandom_range(TOTAL - 1)), 8'($urandom), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Strobes"}, {wProm, wObj, wTile, wSnd, wCpu}, 5'b0);
    checkOutput({tag, "Addr"}, wrAddr, 16'h0);
    checkOutput({tag, "Data"}, wrData, 8'h0);
    checkOutput({tag, "CoreRstn"}, coreRstn, 1'b0);
    checkOutput({tag, "Ok"}, dlOk, 1'b0);
    checkOutput({tag, "Err"}, dlErr, 1'b0);
    checkOutput({tag, "Cnt"}, byteCnt, 19'h0);
  endtask

  initial begin
    int cyc;
    rstn = 0; act = 0; wr = 0; req = 0; addr = '0; data = '0;
    repeat (3) @(posedge clock);
    #1;
    checkResetValues("reset");
    monEn = 1;
    rstn  = 1;

    $display("[TB] writes and reset requests while holding");
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 1'($urandom_range(1)), 19'($urandom_range(TOTAL)), 8'($urandom),
                    1'($urandom_range(1)));

    $display("[TB] short randomized downloads");
    for (int k = 0; k < 4; k++) begin
      download($urandom_range(300, 1), -1, 30, 1, 0);
      repeat (5) applyStimulus(0, 0, '0, '0, 0);
      checkOutput("shortErr", dlErr, 1'b1);
      checkOutput("shortCoreRstn", coreRstn, 1'b0);
    end

    $display("[TB] full download, back-to-back");
    for (int r = 0; r < 5; r++) strbCnt[r] = 0;
    download(TOTAL, -1, 0, 0, 1);
    for (int r = 0; r < 5; r++) checkOutput($sformatf("regionCount%0d", r), strbCnt[r], sizeOf(r));
    checkOutput("fullCnt", byteCnt, TOTAL);
    checkOutput("fullOk", dlOk, 1'b1);
    cyc = 0;
    while (!coreRstn && cyc < 3000) begin
      applyStimulus(0, 0, '0, '0, 0);
      cyc++;
    end
    checkOutput("releaseDelay", cyc + 1, SETTLE_CYC);

    $display("[TB] reset request pulse in RUN");
    for (int i = 0; i < 30; i++)
      applyStimulus(0, 1'($urandom_range(1)), 19'($urandom_range(TOTAL)), 8'($urandom), 0);
    applyStimulus(0, 0, '0, '0, 1);
    checkOutput("reqCoreRstn", coreRstn, 1'b0);
    repeat (49) applyStimulus(0, 0, '0, '0, 1);
    cyc = 0;
    while (!coreRstn && cyc < 3000) begin
      applyStimulus(0, 0, '0, '0, 0);
      cyc++;
    end
    checkOutput("reqReleaseDelay", cyc, SETTLE_CYC);

    $display("[TB] random reset request noise");
    for (int i = 0; i < 300; i++)
      applyStimulus(0, 1'($urandom_range(1)), 19'($urandom_range(TOTAL)), 8'($urandom),
                    1'($urandom_range(15) == 0));
    cyc = 0;
    while (!coreRstn && cyc < 3000) begin
      applyStimulus(0, 0, '0, '0, 0);
      cyc++;
    end
    checkOutput("noiseRecover", coreRstn, 1'b1);

    $display("[TB] full download with an extra out-of-range byte");
    download(TOTAL, $urandom_range(TOTAL - 1), 0, 0, 0);
    checkOutput("ovfCnt", byteCnt, TOTAL + 1);
    checkOutput("ovfErr", dlErr, 1'b1);
    checkOutput("ovfOk", dlOk, 1'b0);
    repeat (20) applyStimulus(0, 0, '0, '0, 1'($urandom_range(1)));
    checkOutput("ovfCoreRstn", coreRstn, 1'b0);

    $display("[TB] reset in the middle of a download");
    applyStimulus(1, 0, '0, '0, 0);
    for (int i = 0; i < 40; i++)
      applyStimulus(1, 1'($urandom_range(1)), 19'($urandom_range(TOTAL - 1)), 8'($urandom), 0);
    @(negedge clock);
    rstn = 0;
    #1;
    checkResetValues("midLoad");
    act = 0; wr = 0;
    @(posedge clock);
    #1;
    rstn = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 19'($urandom_range(TOTAL - 1)), 8'($urandom), 1'($urandom_range(1)));
      checkOutput("holdNoStrobe", {wProm, wObj, wTile, wSnd, wCpu}, 5'b0);
    end
    checkOutput("holdCnt", byteCnt, 19'h0);
    checkOutput("holdCoreRstn", coreRstn, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
